// File: rtl/pla_sweep_pkg.sv
// Shared types and constants for the PLA truth-table sweep controller.
package pla_sweep_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSample,
    StEmit,
    StFin
  } state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam int unsigned DefNIn   = 10;
  localparam int unsigned DefWordW = 32;
  localparam int unsigned DefSettle = 0;

endpackage

// File: rtl/pla_sweep_crc16.sv
// WORD_W-bit parallel CRC-16-CCITT update, data consumed MSB first.
module pla_sweep_crc16
  import pla_sweep_pkg::*;
#(
  parameter int unsigned WORD_W = DefWordW
) (
  input  logic [15:0]       crc_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [15:0]       crc_o
);

  // Unrolled bit-serial LFSR over the whole word
  always_comb begin
    logic [15:0] c;
    logic        fb;
    c = crc_i;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      fb = c[15] ^ data_i[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    crc_o = c;
  end

endmodule

// File: rtl/pla_sweep_ctrl.sv
// Exhaustive sweep sequencer for a single-output combinational netlist.
// Drives every minterm, samples y_i, packs samples into WORD_W-bit words
// streamed over valid/ready, and counts onset minterms.
// Optional: define SWEEP_CRC_EN to add crc_o (CRC-16-CCITT of emitted words).
module pla_sweep_ctrl
  import pla_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = DefNIn,
  parameter int unsigned WORD_W = DefWordW,
  parameter int unsigned SETTLE = DefSettle
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [N_IN-1:0]   x_o,
  input  logic              y_i,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_IN:0]     onset_cnt
`ifdef SWEEP_CRC_EN
  ,
  output logic [15:0]       crc_o
`endif
);

  localparam int unsigned BitW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [N_IN-1:0] WordMask = N_IN'(WORD_W - 1);
  localparam logic [N_IN-1:0] LastIdx  = '1;
  // Where the sweep goes after a vector is advanced: settle wait or straight to sampling
  localparam state_e StStep = (SETTLE > 0) ? StApply : StSample;

  state_e              state_q;
  logic [N_IN-1:0]     index_q;
  logic [3:0]          settle_q;
  logic [WORD_W-1:0]   shreg_q;
  logic [WORD_W-1:0]   shreg_set;
  logic [WORD_W-1:0]   data_q;
  logic [N_IN:0]       onset_q;
  logic                busy_q, done_q, valid_q;
  logic [BitW-1:0]     bit_pos;
  logic                last_bit;

  assign bit_pos  = BitW'(index_q & WordMask);
  assign last_bit = ((index_q & WordMask) == WordMask);

  // Packing register with the current sample merged in
  always_comb begin
    shreg_set          = shreg_q;
    shreg_set[bit_pos] = y_i;
  end

  // Sweep FSM; all outputs are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      index_q  <= '0;
      settle_q <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      onset_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        // Partial word is dropped; onset count keeps its partial value
        state_q <= StIdle;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              index_q  <= '0;
              onset_q  <= '0;
              shreg_q  <= '0;
              settle_q <= '0;
              busy_q   <= 1'b1;
              state_q  <= StStep;
            end
          end
          StApply: begin
            if (settle_q == 4'(SETTLE - 1)) begin
              settle_q <= '0;
              state_q  <= StSample;
            end else begin
              settle_q <= settle_q + 4'd1;
            end
          end
          StSample: begin
            shreg_q <= shreg_set;
            onset_q <= onset_q + {{N_IN{1'b0}}, y_i};
            if (last_bit) begin
              data_q  <= shreg_set;
              valid_q <= 1'b1;
              state_q <= StEmit;
            end else begin
              index_q <= index_q + N_IN'(1);
              state_q <= StStep;
            end
          end
          StEmit: begin
            // x_o stays on the word's last minterm until the word is taken
            if (out_ready) begin
              valid_q <= 1'b0;
              if (index_q == LastIdx) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= StFin;
              end else begin
                index_q <= index_q + N_IN'(1);
                state_q <= StStep;
              end
            end
          end
          StFin: begin
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign x_o       = index_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign onset_cnt = onset_q;

`ifdef SWEEP_CRC_EN
  logic [15:0] crc_q;
  logic [15:0] crc_next;

  pla_sweep_crc16 #(
    .WORD_W(WORD_W)
  ) u_crc (
    .crc_i (crc_q),
    .data_i(data_q),
    .crc_o (crc_next)
  );

  // CRC restarts on an accepted start and folds in each accepted word
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC_INIT;
    end else if ((state_q == StIdle) && start) begin
      crc_q <= CRC_INIT;
    end else if ((state_q == StEmit) && out_ready && !abort) begin
      crc_q <= crc_next;
    end
  end

  assign crc_o = crc_q;
`endif

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// Scoreboard bench for pla_sweep_ctrl: the netlist is a truth-table array,
// expected words are slices of that array, onset is its popcount.
module tb_pla_sweep_ctrl;

  localparam int N  = 10;
  localparam int W  = 32;
  localparam int NM = 1 << N;
  localparam int NW = NM / W;
  localparam int MaxWait = 5000;

  logic clk = 1'b0;
  logic rst, start, start1, abort;
  logic ready_ctl, rnd_bit, rand_ready, out_ready;
  logic [NM-1:0] tt;

  logic          busy0, done0, valid0, y0;
  logic [N-1:0]  x0;
  logic [W-1:0]  data0;
  logic [N:0]    onset0;
  logic          busy1, done1, valid1, y1, d1, d2, d3;
  logic [N-1:0]  x1;
  logic [W-1:0]  data1;
  logic [N:0]    onset1;
`ifdef SWEEP_CRC_EN
  logic [15:0]   crc0, crc1;
`endif

  int checks = 0;
  int errors = 0;
  logic [W+N-1:0] exp0[$];
  logic [W+N-1:0] exp1[$];
  logic [W+N-1:0] ent0, ent1;
  logic [N:0] exp_onset0, exp_onset1;
  int words0 = 0, words1 = 0, base0 = 0, base1 = 0;
  int dones0 = 0, dones1 = 0, exp_dones0 = 0, exp_dones1 = 0;
  logic done0_prev = 1'b0;
  int ncyc;

  always #5 clk = ~clk;

  assign out_ready = ready_ctl & rnd_bit;
  assign y0 = tt[x0];

  // Netlist copy with a 3-stage registered output, for the settle-time instance
  always @(posedge clk) begin
    if (rst) begin
      d1 <= 1'b0; d2 <= 1'b0; d3 <= 1'b0;
    end else begin
      d1 <= tt[x1]; d2 <= d1; d3 <= d2;
    end
  end
  assign y1 = d3;

  always @(posedge clk) begin
    #1 rnd_bit = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  pla_sweep_ctrl #(.N_IN(N), .WORD_W(W), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy0), .done(done0),
    .x_o(x0), .y_i(y0), .out_data(data0), .out_valid(valid0), .out_ready(out_ready),
    .onset_cnt(onset0)
`ifdef SWEEP_CRC_EN
    , .crc_o(crc0)
`endif
  );

  pla_sweep_ctrl #(.N_IN(N), .WORD_W(W), .SETTLE(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .busy(busy1), .done(done1),
    .x_o(x1), .y_i(y1), .out_data(data1), .out_valid(valid1), .out_ready(1'b1),
    .onset_cnt(onset1)
`ifdef SWEEP_CRC_EN
    , .crc_o(crc1)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor for the zero-settle instance
  always @(negedge clk) begin
    if (!rst) begin
      if (valid0 && out_ready) begin
        if (exp0.size() == 0) begin
          check("dut0 unexpected word", 64'(data0), 64'hDEAD_0000);
        end else begin
          ent0 = exp0.pop_front();
          check("dut0 word", 64'(data0), 64'(ent0[W-1:0]));
          check("dut0 x_o at emit", 64'(x0), 64'(ent0[W+N-1:W]));
        end
        words0++;
      end
      if (done0) begin
        dones0++;
        check("dut0 onset at done", 64'(onset0), 64'(exp_onset0));
        check("dut0 words per sweep", 64'(words0 - base0), 64'(NW));
        check("dut0 busy low at done", 64'(busy0), 64'(0));
        check("dut0 done one cycle", 64'(done0_prev), 64'(0));
      end
      done0_prev = done0;
    end
  end

  // Monitor for the settle-time instance
  always @(negedge clk) begin
    if (!rst) begin
      if (valid1) begin
        if (exp1.size() == 0) begin
          check("dut1 unexpected word", 64'(data1), 64'hDEAD_0001);
        end else begin
          ent1 = exp1.pop_front();
          check("dut1 word", 64'(data1), 64'(ent1[W-1:0]));
        end
        words1++;
      end
      if (done1) begin
        dones1++;
        check("dut1 onset at done", 64'(onset1), 64'(exp_onset1));
        check("dut1 words per sweep", 64'(words1 - base1), 64'(NW));
      end
    end
  end

  task automatic set_tt(input int mode);
    for (int i = 0; i < NM; i++) begin
      case (mode)
        0:       tt[i] = i[0];
        1:       tt[i] = 1'b1;
        2:       tt[i] = 1'b0;
        default: tt[i] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic load_exp(input bit both);
    for (int k = 0; k < NW; k++) begin
      exp0.push_back({N'(k * W + W - 1), tt[k*W +: W]});
      if (both) exp1.push_back({N'(k * W + W - 1), tt[k*W +: W]});
    end
    exp_onset0 = (N + 1)'($countones(tt));
    exp_onset1 = (N + 1)'($countones(tt));
  endtask

  task automatic start_sweep(input bit both);
    @(posedge clk);
    #1 start = 1'b1;
    start1 = both;
    base0 = words0;
    if (both) base1 = words1;
    @(posedge clk);
    #1 start = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    check("busy after start", 64'(busy0), 64'(1));
  endtask

  task automatic wait_done0(output int n);
    n = 0;
    while (!done0 && n < MaxWait) begin
      @(negedge clk);
      n++;
    end
    if (n >= MaxWait) check("dut0 done timeout", 64'(0), 64'(1));
    else exp_dones0++;
    @(posedge clk);
  endtask

  task automatic wait_done1();
    int n = 0;
    while (!done1 && n < MaxWait) begin
      @(negedge clk);
      n++;
    end
    if (n >= MaxWait) check("dut1 done timeout", 64'(0), 64'(1));
    else exp_dones1++;
    @(posedge clk);
  endtask

  task automatic wait_words0(input int target);
    int n = 0;
    while ((words0 - base0) < target && n < MaxWait) begin
      @(negedge clk);
      n++;
    end
    if (n >= MaxWait) check("dut0 word wait timeout", 64'(0), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, 64'(busy0), 64'(0));
    check({tag, " done"}, 64'(done0), 64'(0));
    check({tag, " x_o"}, 64'(x0), 64'(0));
    check({tag, " out_valid"}, 64'(valid0), 64'(0));
    check({tag, " out_data"}, 64'(data0), 64'(0));
    check({tag, " onset_cnt"}, 64'(onset0), 64'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; abort = 1'b0;
    ready_ctl = 1'b1; rand_ready = 1'b0; rnd_bit = 1'b1;
    tt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Fixed functions at full throughput, with the minimum sweep length
    for (int m = 0; m < 3; m++) begin
      set_tt(m);
      load_exp(1'b0);
      start_sweep(1'b0);
      wait_done0(ncyc);
      check("sweep cycles", 64'(ncyc + 1), 64'(NM + NW + 1));
    end

    // Consumer stalls on the third word
    set_tt(3);
    load_exp(1'b0);
    start_sweep(1'b0);
    begin
      int n = 0;
      while (x0 != N'(94) && n < MaxWait) begin
        @(negedge clk);
        n++;
      end
      if (n >= MaxWait) check("stall setup timeout", 64'(0), 64'(1));
    end
    @(posedge clk);
    #1 ready_ctl = 1'b0;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      check("stall out_valid", 64'(valid0), 64'(1));
      check("stall out_data", 64'(data0), 64'(tt[2*W +: W]));
      check("stall x_o", 64'(x0), 64'(95));
    end
    @(posedge clk);
    #1 ready_ctl = 1'b1;
    wait_done0(ncyc);

    // Random back-pressure on random functions
    rand_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      set_tt(3);
      load_exp(1'b0);
      start_sweep(1'b0);
      wait_done0(ncyc);
    end
    rand_ready = 1'b0;

    // Settle-time instance against a delayed netlist sees the same table
    set_tt(3);
    load_exp(1'b1);
    start_sweep(1'b1);
    wait_done0(ncyc);
    wait_done1();

    // Abort after word 10, then a clean sweep
    set_tt(3);
    load_exp(1'b0);
    start_sweep(1'b0);
    wait_words0(10);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort out_valid", 64'(valid0), 64'(0));
    check("abort busy", 64'(busy0), 64'(0));
    repeat (4) begin
      @(negedge clk);
      check("abort no done", 64'(done0), 64'(0));
    end
    exp0.delete();
    set_tt(3);
    load_exp(1'b0);
    start_sweep(1'b0);
    wait_done0(ncyc);

    // Start while busy is ignored; reset during EMIT clears everything
    set_tt(3);
    load_exp(1'b0);
    start_sweep(1'b0);
    wait_words0(3);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_words0(6);
    @(posedge clk);
    #1 ready_ctl = 1'b0;
    begin
      int n = 0;
      while (!valid0 && n < MaxWait) begin
        @(negedge clk);
        n++;
      end
      check("emit before reset", 64'(valid0), 64'(1));
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid-sweep reset");
    @(posedge clk);
    #1 rst = 1'b0;
    ready_ctl = 1'b1;
    exp0.delete();

    // Full sweep after the reset
    set_tt(0);
    load_exp(1'b0);
    start_sweep(1'b0);
    wait_done0(ncyc);

    repeat (3) @(posedge clk);
    check("dut0 done count", 64'(dones0), 64'(exp_dones0));
    check("dut1 done count", 64'(dones1), 64'(exp_dones1));
    check("dut0 queue drained", 64'(exp0.size()), 64'(0));
    check("dut1 queue drained", 64'(exp1.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
